// File: rtl/fir_input_sequencer.sv
// Host-to-FIR feeder: sample FIFO, coefficient bank, load burst, settle gap.
// Optional FIR_SEQ_FLUSH_EN: drain the FIR delay line with zeros when the stream ends.
module fir_input_sequencer #(
  parameter int X_N_SIZE    = 8,
  parameter int NBR_OF_TAPS = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int CFG_LEAD    = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] in_data,
  input  logic                in_cmd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int IW   = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
  localparam int KW   = $clog2(NBR_OF_TAPS + 1);
  localparam int LAST = CFG_LEAD + NBR_OF_TAPS;
  localparam int SW   = $clog2(LAST + 1);
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    LOAD,
    GAP
  } state_t;

  state_t state, state_n;

  logic [SW-1:0] step, step_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [KW-1:0] coef_cnt;

  logic [X_N_SIZE-1:0] bank [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0] mem  [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic full, empty, load_pend;
  logic push, pop, coef_push, coef_clr, feed;
  logic [X_N_SIZE-1:0] x_n_n;
  logic tvalid_n, set_n;

`ifdef FIR_SEQ_FLUSH_EN
  localparam int FLUSH_LEN = 2 * NBR_OF_TAPS - 1;
  localparam int FW = $clog2(FLUSH_LEN + 1);
  logic [FW-1:0] flush_cnt, flush_n;
`endif

  // Last coefficient first so bank[0] ends up in the FIR's taps[0].
  function automatic logic [IW-1:0] bank_idx(input logic [SW-1:0] k);
    if (int'(k) < CFG_LEAD) return IW'(NBR_OF_TAPS - 1);
    return IW'(NBR_OF_TAPS - 1 - int'(k) + CFG_LEAD);
  endfunction

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign load_pend = (coef_cnt == KW'(NBR_OF_TAPS));

  assign in_ready = in_cmd
                  ? (coef_cnt < KW'(NBR_OF_TAPS) && state != LOAD)
                  : !full;

  assign push      = in_valid & in_ready & ~in_cmd;
  assign coef_push = in_valid & in_ready & in_cmd;

  always_comb begin
    state_n  = state;
    step_n   = step;
    gap_n    = gap_cnt;
    x_n_n    = '0;
    tvalid_n = 1'b0;
    set_n    = 1'b0;
    pop      = 1'b0;
    coef_clr = 1'b0;
    feed     = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    flush_n  = flush_cnt;
`endif
    unique case (state)
      LOAD: begin
        if (step == SW'(LAST)) begin
          state_n  = GAP;
          gap_n    = '0;
          coef_clr = 1'b1;
        end else begin
          set_n  = 1'b1;
          x_n_n  = bank[bank_idx(step)];
          step_n = step + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) feed = 1'b1;
        else gap_n = gap_cnt + 1'b1;
      end
      default: feed = 1'b1;
    endcase

    if (feed) begin
      if (load_pend) begin
        state_n = LOAD;
        set_n   = 1'b1;
        x_n_n   = bank[bank_idx(SW'(0))];
        step_n  = SW'(1);
`ifdef FIR_SEQ_FLUSH_EN
        flush_n = '0;
`endif
      end else if (!empty) begin
        pop      = 1'b1;
        tvalid_n = 1'b1;
        x_n_n    = mem[rd_ptr];
        state_n  = STREAM;
`ifdef FIR_SEQ_FLUSH_EN
        flush_n  = '0;
`endif
      end else begin
`ifdef FIR_SEQ_FLUSH_EN
        if (state == STREAM && flush_cnt != FW'(FLUSH_LEN)) begin
          tvalid_n = 1'b1;
          flush_n  = flush_cnt + 1'b1;
        end else begin
          state_n = IDLE;
          flush_n = '0;
        end
`else
        state_n = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      step           <= '0;
      gap_cnt        <= '0;
      coef_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      x_n            <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      busy           <= 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
      flush_cnt      <= '0;
`endif
    end else begin
      state          <= state_n;
      step           <= step_n;
      gap_cnt        <= gap_n;
      x_n            <= x_n_n;
      fir_tvalid     <= tvalid_n;
      fir_set_coeffs <= set_n;
      busy           <= (state_n == LOAD) || (state_n == GAP);
`ifdef FIR_SEQ_FLUSH_EN
      flush_cnt      <= flush_n;
`endif
      if (coef_clr) coef_cnt <= '0;
      else if (coef_push) coef_cnt <= coef_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
    if (coef_push) bank[coef_cnt[IW-1:0]] <= in_data;
  end

endmodule
